// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder.
//   fmt_t    : instruction format selector (load-I, store-S, branch-B, R)
//   OP_*     : fixed 7-bit opcode per format
//   NOP_WORD : canonical NOP (addi x0,x0,0) used to replace bad immediates
//   state_t  : job FSM state encoding
//   enc_t    : encoder result (final word + legality flag)
//   encode_fields : pure combinational field packer with range check
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_LOAD   = 2'b00,
    FMT_STORE  = 2'b01,
    FMT_BRANCH = 2'b10,
    FMT_R      = 2'b11
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] word;
    logic        legal;
  } enc_t;

  // Packs the fields for the selected format. An out-of-range immediate
  // yields legal=0 and the NOP word, so callers can write word unconditionally.
  function automatic enc_t encode_fields(
    input fmt_t        fmt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    enc_t        res;
    logic [31:0] raw;
    logic        legal;
    // I/S hold a 12-bit signed value: bits 31..11 must be pure sign extension.
    logic        fits12;
    // B holds a 13-bit signed, even value: bits 31..12 sign extension, bit 0 clear.
    logic        fits13_even;
    fits12      = (&imm[31:11]) | ~(|imm[31:11]);
    fits13_even = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    raw   = 32'h0;
    legal = 1'b1;
    unique case (fmt)
      FMT_LOAD: begin
        raw   = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        legal = fits12;
      end
      FMT_STORE: begin
        raw   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        legal = fits12;
      end
      FMT_BRANCH: begin
        raw   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        legal = fits13_even;
      end
      FMT_R: begin
        raw   = {funct7, rs2, rs1, funct3, rd, OP_R};
        legal = 1'b1;
      end
    endcase
    res.word  = legal ? raw : NOP_WORD;
    res.legal = legal;
    return res;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bus interfaces of the instruction encoder.
//   instr_field_if : decoded-field input stream (in_valid/in_ready + fields)
//   imem_wr_if     : instruction-memory write port (imem_we/addr/wdata, imem_ready)
//
// Handshake rule for both streams: a beat transfers on a rising clk edge where
// valid (in_valid / imem_we) and ready (in_ready / imem_ready) are both 1.
// While valid=1 and ready=0 the source holds its payload stable; ready may be
// asserted or withdrawn independently of valid.
interface instr_field_if;
  import instr_encoder_pkg::*;
  logic        in_valid;
  logic        in_ready;
  fmt_t        fmt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready
  );
  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready
  );
endinterface

interface imem_wr_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;

  modport master (
    output imem_we, imem_addr, imem_wdata,
    input  imem_ready
  );
  modport slave (
    input  imem_we, imem_addr, imem_wdata,
    output imem_ready
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// instr_fifo: synchronous FIFO holding encoded words awaiting the IMEM write.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write a word (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   rdata      : head word (show-ahead)
//   full/empty : occupancy flags derived from registered pointers
module instr_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra wrap bit per pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes a job of `count` instructions from decoded fields into
// 32-bit words and writes them to consecutive IMEM word addresses.
//   clk, rst_n      : clock, async active-low reset
//   start           : job start pulse (honoured in IDLE only)
//   base_addr[31:0] : first IMEM byte address (bits 1:0 ignored)
//   count[15:0]     : instructions in the job (0 completes immediately)
//   busy, done      : job active / one-cycle completion pulse
//   fld (slave)     : field input stream, see instr_field_if
//   imem (master)   : IMEM write port, see imem_wr_if
//   err, err_count  : sticky bad-immediate flag and saturating count
//   state_dbg       : current FSM state
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [15:0]        count,
  output logic               busy,
  output logic               done,
  instr_field_if.slave       fld,
  imem_wr_if.master          imem,
  output logic               err,
  output logic [15:0]        err_count,
  output state_t             state_dbg
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic [15:0] accepted_q;
  logic        done_q;
  logic        done_d;
  logic        err_q;
  logic [15:0] err_count_q;

  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;
  logic        start_ok;
  enc_t        enc;

  logic [1:0]  unused_base_lsbs;
  assign unused_base_lsbs = base_addr[1:0];

  assign start_ok = (state_q == ST_IDLE) && start;
  assign push     = fld.in_valid & fld.in_ready;
  assign pop      = imem.imem_we & imem.imem_ready;

  always_comb begin
    enc = encode_fields(fld.fmt, fld.rd, fld.rs1, fld.rs2,
                        fld.funct3, fld.funct7, fld.imm);
  end

  instr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and done request.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != 16'd0) state_d = ST_RUN;
          else                done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (push && (accepted_q == count_q - 16'd1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. in_ready looks only at full, never at a pending pop, so a
  // full FIFO never sees a simultaneous push and pop.
  always_comb begin
    fld.in_ready = (state_q == ST_RUN) && !fifo_full && (accepted_q < count_q);
    busy         = (state_q != ST_IDLE);
    imem.imem_we = !fifo_empty;
  end

  // Job datapath: address/count bookkeeping and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= 32'h0;
      count_q     <= 16'h0;
      accepted_q  <= 16'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 16'h0;
    end else begin
      done_q <= done_d;
      if (start_ok) begin
        err_q       <= 1'b0;
        err_count_q <= 16'h0;
        if (count != 16'd0) begin
          addr_q     <= {base_addr[31:2], 2'b00};
          count_q    <= count;
          accepted_q <= 16'h0;
        end
      end
      if (push) begin
        accepted_q <= accepted_q + 16'd1;
        if (!enc.legal) begin
          err_q <= 1'b1;
          if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
        end
      end
      // Address follows the head word; it advances only when IMEM takes it,
      // so address and data stay paired through stalls.
      if (pop) addr_q <= addr_q + 32'd4;
    end
  end

  assign imem.imem_addr  = addr_q;
  // Hide stale storage when nothing is pending (and after reset).
  assign imem.imem_wdata = fifo_empty ? 32'h0 : fifo_head;
  assign done            = done_q;
  assign err             = err_q;
  assign err_count       = err_count_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] err_count;
  state_t      state_dbg;

  instr_field_if fld();
  imem_wr_if     imem();

  instr_encoder #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .fld       (fld),
    .imem      (imem),
    .err       (err),
    .err_count (err_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard on the IMEM port ----------------
  always @(negedge clk) begin
    if (imem.imem_we === 1'b1 && imem.imem_ready === 1'b1) begin
      n_writes++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("wdata", imem.imem_wdata, exp_q.pop_front());
        check("waddr", imem.imem_addr, exp_addr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input fmt_t f, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int waited = 0;
    fld.fmt = f; fld.rd = rd; fld.rs1 = rs1; fld.rs2 = rs2;
    fld.funct3 = f3; fld.funct7 = f7; fld.imm = imm;
    fld.in_valid = 1'b1;
    @(negedge clk);
    while (!fld.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!fld.in_ready) begin
      check("send_timeout", 32'(fld.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    fld.in_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] w, input logic [31:0] a);
    exp_q.push_back(w);
    exp_addr_q.push_back(a);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // R-type add/sub words: rs1=1, rs2=2, rd=i+1 (last one funct7=0100000)
  logic [31:0] r_tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    r_tbl[0] = 32'h002080B3; r_tbl[1] = 32'h00208133;
    r_tbl[2] = 32'h002081B3; r_tbl[3] = 32'h00208233;
    r_tbl[4] = 32'h002082B3; r_tbl[5] = 32'h00208333;
    r_tbl[6] = 32'h002083B3; r_tbl[7] = 32'h40208433;

    rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; count = 16'h0;
    fld.in_valid = 1'b0; fld.fmt = FMT_LOAD; fld.rd = 5'd0; fld.rs1 = 5'd0;
    fld.rs2 = 5'd0; fld.funct3 = 3'd0; fld.funct7 = 7'd0; fld.imm = 32'h0;
    imem.imem_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(fld.in_ready), 32'd0);
    check("rst_we", 32'(imem.imem_we), 32'd0);
    check("rst_addr", imem.imem_addr, 32'h0);
    check("rst_wdata", imem.imem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Single lw
    imem.imem_ready = 1'b1;
    expect_write(32'h00812283, 32'h100);
    do_start(32'h100, 16'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state", 32'(state_dbg), 32'(ST_RUN));
    send(FMT_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    wait_done("t1_done");
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_writes", 32'(n_writes), 32'd1);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // sw + beq, base with low bits set
    expect_write(32'hFE612E23, 32'h200);
    expect_write(32'hFE208CE3, 32'h204);
    do_start(32'h203, 16'd2);
    send(FMT_STORE, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, 32'hFFFF_FFFC);
    send(FMT_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFF8);
    wait_done("t2_done");
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check("t2_err", 32'(err), 32'd0);

    // Bad immediates become NOP and bump the error counter
    expect_write(NOP_WORD, 32'h300);
    expect_write(NOP_WORD, 32'h304);
    do_start(32'h300, 16'd2);
    send(FMT_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3);
    send(FMT_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'h800);
    wait_done("t3_done");
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_err", 32'(err), 32'd1);
    check("t3_err_count", 32'(err_count), 32'd2);

    // count=0: immediate done, errors cleared, stays idle
    do_start(32'h600, 16'd0);
    @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_state", 32'(state_dbg), 32'(ST_IDLE));
    check("t4_err", 32'(err), 32'd0);
    check("t4_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 32'd0);

    // Backpressure: 8 words, IMEM stalled, addresses wrap past 2^32
    imem.imem_ready = 1'b0;
    for (int i = 0; i < 8; i++) expect_write(r_tbl[i], 32'hFFFF_FFF0 + 32'(i * 4));
    do_start(32'hFFFF_FFF0, 16'd8);
    for (int i = 0; i < 4; i++)
      send(FMT_R, 5'(i + 1), 5'd1, 5'd2, 3'd0, (i == 7) ? 7'b0100000 : 7'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_full_in_ready", 32'(fld.in_ready), 32'd0);
      check("t5_stall_we", 32'(imem.imem_we), 32'd1);
      check("t5_stall_addr", imem.imem_addr, 32'hFFFF_FFF0);
      check("t5_stall_wdata", imem.imem_wdata, r_tbl[0]);
    end
    check("t5_no_write_yet", 32'(n_writes), 32'd5);
    imem.imem_ready = 1'b1;
    for (int i = 4; i < 8; i++)
      send(FMT_R, 5'(i + 1), 5'd1, 5'd2, 3'd0, (i == 7) ? 7'b0100000 : 7'd0, 32'h0);
    wait_done("t5_done");
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_writes", 32'(n_writes), 32'd13);

    // Reset in DRAIN with 3 buffered words
    imem.imem_ready = 1'b0;
    do_start(32'h400, 16'd3);
    for (int i = 0; i < 3; i++)
      send(FMT_R, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    @(negedge clk);
    check("t6_drain", 32'(state_dbg), 32'(ST_DRAIN));
    check("t6_we_before", 32'(imem.imem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    imem.imem_ready = 1'b1;
    #1;
    check("t6_rst_we", 32'(imem.imem_we), 32'd0);
    check("t6_rst_addr", imem.imem_addr, 32'h0);
    check("t6_rst_wdata", imem.imem_wdata, 32'h0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("t6_rst_in_ready", 32'(fld.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_post_we", 32'(imem.imem_we), 32'd0);
      check("t6_post_state", 32'(state_dbg), 32'(ST_IDLE));
    end
    check("t6_writes", 32'(n_writes), 32'd13);

    // Still operational after reset
    expect_write(32'h00812283, 32'h500);
    do_start(32'h500, 16'd1);
    send(FMT_LOAD, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
    wait_done("t7_done");
    check("t7_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the encoded-word buffer depth (power of two, >=2).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: clk (input, 1, rising-edge clock), then rst_n (input, 1, async active-low reset).
REQ-003 The block SHALL have these job-control ports: start (input, 1, job start pulse), base_addr (input, 32, first IMEM byte address; bits[1:0] ignored), count (input, 16, instructions in job), busy (output, 1, job active), done (output, 1, one-cycle completion pulse).
REQ-004 The block SHALL have these field-input ports: in_valid (input, 1), in_ready (output, 1), fmt (input, 2: 00 load-I, 01 store-S, 10 branch-B, 11 R), rd/rs1/rs2 (input, 5 each), funct3 (input, 3), funct7 (input, 7), imm (input, 32, signed immediate).
REQ-005 The block SHALL have these IMEM write-port ports: imem_we (output, 1), imem_addr (output, 32), imem_wdata (output, 32), imem_ready (input, 1, write accepted this cycle).
REQ-006 The block SHALL have these error ports: err (output, 1, sticky bad-immediate flag), err_count (output, 16).

Function
REQ-007 The opcode SHALL be fixed per fmt: 0000011, 0100011, 1100011, 0110011.
REQ-008 Encoding SHALL be: I {imm[11:0],rs1,funct3,rd,op}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; R {funct7,rs2,rs1,funct3,rd,op}.
REQ-009 The range check SHALL be: I/S legal iff imm[31:11] all equal; B legal iff imm[31:12] all equal and imm[0]=0; R always legal.
REQ-010 An illegal word SHALL be replaced by NOP 0x00000013, set err, and increment err_count (saturating at 0xFFFF); the slot and its address SHALL still be consumed.
REQ-011 The FSM SHALL have states IDLE, RUN, DRAIN. IDLE->RUN on start with count!=0, latching base_addr and count. start with count=0 SHALL pulse done the next cycle and remain in IDLE.
REQ-012 In RUN, in_ready SHALL be 1 iff the FIFO is not full and accepted<count; a transfer is in_valid&in_ready. RUN->DRAIN when the count-th input is accepted.
REQ-013 Each accepted word SHALL be encoded combinationally and written to the FIFO at the accept edge. imem_we SHALL be asserted the following cycle at the earliest (1-cycle latency).
REQ-014 imem_we SHALL equal FIFO non-empty. The head word SHALL be popped on imem_we&imem_ready. imem_addr SHALL start at {base_addr[31:2],2'b00} and increment by 4 per pop, wrapping modulo 2^32.
REQ-015 imem_addr/imem_wdata SHALL remain stable while imem_we=1 and imem_ready=0.
REQ-016 A simultaneous push and pop on a full FIFO SHALL NOT be allowed; in_ready uses full only. Push and pop in the same cycle otherwise SHALL keep the occupancy unchanged.
REQ-017 DRAIN->IDLE when the FIFO is empty after the last pop; done SHALL pulse for 1 cycle on that transition. busy=1 in RUN and DRAIN.
REQ-018 start SHALL be ignored unless in IDLE.
REQ-019 err/err_count SHALL clear on an accepted start (IDLE only).

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, empty the FIFO, and set in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, err_count=0.
REQ-021 Reset mid-job SHALL discard all buffered words without any write; the first post-reset cycle SHALL be IDLE.

Structure
REQ-022 A shared package SHALL hold the fmt enum, the four opcode constants, the NOP constant and the FSM state typedef.
REQ-023 The FIFO SHALL be a sub-module named instr_fifo (parameter FIFO_DEPTH, 32-bit, registered pointers, full/empty outputs).

Verification
REQ-024 Start base=0x100, count=1; lw rd=5 rs1=2 f3=010 imm=8 -> one write 0x00812283 @0x100, then done.
REQ-025 sw rs2=6 rs1=2 f3=010 imm=-4 -> 0xFE612E23; beq rs1=1 rs2=2 imm=-8 -> 0xFE208CE3, at consecutive addresses.
REQ-026 Branch imm=3 and load imm=0x800 -> both written as 0x00000013, err=1, err_count=2.
REQ-027 count=8 with imem_ready held 0 -> in_ready drops after FIFO_DEPTH accepts; on release, 8 writes in order, addresses base..base+28.
REQ-028 rst_n asserted in DRAIN with 3 words buffered -> no further imem_we, all outputs at reset values, IDLE.
